// File: rtl/coin_input_conditioner.sv
// Coin button front end: 2-flop sync, per-channel debounce FSM, lock-gated pulse arbiter.
// Optional macro COIN_TALLY_EN adds saturating 8-bit nickel/dime tallies with a synchronous clear.

module coin_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic confirm_o
);
  // state | meaning
  // IDLE  | button released and stable, waiting for a press
  // ARM   | press seen, counting stable-high cycles before confirming
  // HELD  | press confirmed, waiting for release (no auto-repeat)
  // REL   | release seen, counting stable-low cycles before re-arming
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HELD, S_REL} state_e;

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (sync2_q) begin
          state_d = S_ARM;
          cnt_d   = '0;
        end
      end
      S_ARM: begin
        if (!sync2_q)        state_d = S_IDLE;
        else if (cnt_q == TC) state_d = S_HELD;
        else                 cnt_d   = cnt_q + CNT_W'(1);
      end
      S_HELD: begin
        if (!sync2_q) begin
          state_d = S_REL;
          cnt_d   = '0;
        end
      end
      S_REL: begin
        // a bounce back high during release is the same press
        if (sync2_q)          state_d = S_HELD;
        else if (cnt_q == TC) state_d = S_IDLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    confirm_o = (state_q == S_ARM) && sync2_q && (cnt_q == TC);
  end
endmodule

module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       lock,
  output logic       nb,
  output logic       db,
  output logic       coin_reject
`ifdef COIN_TALLY_EN
  ,
  input  logic       tally_clr,
  output logic [7:0] nickel_tally,
  output logic [7:0] dime_tally
`endif
);
  logic conf_n, conf_d;
  logic want_n, want_d;
  logic emit_n, emit_d, reject;
  logic pend_n_q, pend_n_d, pend_d_q, pend_d_d;
  logic nb_q, db_q, rej_q;

  coin_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_nickel (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (nickel_raw),
    .confirm_o (conf_n)
  );

  coin_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_dime (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_i     (dime_raw),
    .confirm_o (conf_d)
  );

  // One pulse per cycle: pending coins go first, then dime before nickel.
  always_comb begin
    want_n = pend_n_q | conf_n;
    want_d = pend_d_q | conf_d;
    emit_n = 1'b0;
    emit_d = 1'b0;
    reject = 1'b0;
    if (lock)          reject = want_n | want_d;
    else if (pend_n_q) emit_n = 1'b1;
    else if (pend_d_q) emit_d = 1'b1;
    else if (conf_d)   emit_d = 1'b1;
    else if (conf_n)   emit_n = 1'b1;
    pend_n_d = !lock && want_n && !emit_n;
    pend_d_d = !lock && want_d && !emit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nb_q     <= 1'b0;
      db_q     <= 1'b0;
      rej_q    <= 1'b0;
      pend_n_q <= 1'b0;
      pend_d_q <= 1'b0;
    end else begin
      nb_q     <= emit_n;
      db_q     <= emit_d;
      rej_q    <= reject;
      pend_n_q <= pend_n_d;
      pend_d_q <= pend_d_d;
    end
  end

  assign nb          = nb_q;
  assign db          = db_q;
  assign coin_reject = rej_q;

`ifdef COIN_TALLY_EN
  logic [7:0] n_tally_q, d_tally_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_tally_q <= 8'd0;
      d_tally_q <= 8'd0;
    end else if (tally_clr) begin
      n_tally_q <= 8'd0;
      d_tally_q <= 8'd0;
    end else begin
      if (emit_n && (n_tally_q != 8'hFF)) n_tally_q <= n_tally_q + 8'd1;
      if (emit_d && (d_tally_q != 8'hFF)) d_tally_q <= d_tally_q + 8'd1;
    end
  end

  assign nickel_tally = n_tally_q;
  assign dime_tally   = d_tally_q;
`endif
endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
// Tally checks are compiled in only when COIN_TALLY_EN is defined.

module tb_coin_input_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nickel_raw = 1'b0;
  logic dime_raw = 1'b0;
  logic lock = 1'b0;
  logic nb, db, coin_reject;
`ifdef COIN_TALLY_EN
  logic       tally_clr = 1'b0;
  logic [7:0] nickel_tally, dime_tally;
`endif

  int errors = 0;
  int checks = 0;
  int edge_ctr, nb_cnt, db_cnt, rej_cnt, overlap, nb_edge, db_edge, rej_edge;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nickel_raw  (nickel_raw),
    .dime_raw    (dime_raw),
    .lock        (lock),
    .nb          (nb),
    .db          (db),
    .coin_reject (coin_reject)
`ifdef COIN_TALLY_EN
    ,
    .tally_clr    (tally_clr),
    .nickel_tally (nickel_tally),
    .dime_tally   (dime_tally)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    edge_ctr = 0; nb_cnt = 0; db_cnt = 0; rej_cnt = 0; overlap = 0;
    nb_edge = -1; db_edge = -1; rej_edge = -1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_ctr++;
      if (nb === 1'b1) begin nb_cnt++; nb_edge = edge_ctr; end
      if (db === 1'b1) begin db_cnt++; db_edge = edge_ctr; end
      if (coin_reject === 1'b1) begin rej_cnt++; rej_edge = edge_ctr; end
      if (nb === 1'b1 && db === 1'b1) overlap++;
    end
  endtask

  task automatic press_nickel();
    nickel_raw = 1'b1;
    steps(10);
    nickel_raw = 1'b0;
    steps(12);
  endtask

  initial begin
    clr_stats();
    steps(3);
    chk("rst_nb", int'(nb), 0);
    chk("rst_db", int'(db), 0);
    chk("rst_rej", int'(coin_reject), 0);
    rst_n = 1'b1;
    steps(4);

    // clean nickel press
    clr_stats();
    nickel_raw = 1'b1;
    steps(6);
    chk("clean_nb_edge6", int'(nb), 0);
    steps(1);
    chk("clean_nb_edge7", int'(nb), 1);
    steps(13);
    nickel_raw = 1'b0;
    steps(20);
    chk("clean_nb_cnt", nb_cnt, 1);
    chk("clean_nb_edge", nb_edge, 7);
    chk("clean_db_cnt", db_cnt, 0);
    chk("clean_rej_cnt", rej_cnt, 0);

    // dime bounce, then steady, then release bounce
    clr_stats();
    for (int i = 0; i < 10; i++) begin
      dime_raw = (i % 2 == 0);
      steps(1);
    end
    chk("bounce_quiet", db_cnt, 0);
    clr_stats();
    dime_raw = 1'b1;
    steps(10);
    dime_raw = 1'b0; steps(1);
    dime_raw = 1'b1; steps(1);
    dime_raw = 1'b0; steps(1);
    steps(15);
    chk("bounce_db_cnt", db_cnt, 1);
    chk("bounce_db_edge", db_edge, 7);
    chk("bounce_nb_cnt", nb_cnt, 0);

    // simultaneous press: dime first, nickel one cycle later
    clr_stats();
    nickel_raw = 1'b1; dime_raw = 1'b1;
    steps(15);
    nickel_raw = 1'b0; dime_raw = 1'b0;
    steps(15);
    chk("simul_db_edge", db_edge, 7);
    chk("simul_nb_edge", nb_edge, 8);
    chk("simul_db_cnt", db_cnt, 1);
    chk("simul_nb_cnt", nb_cnt, 1);
    chk("simul_overlap", overlap, 0);

    // lock over the confirm cycle
    clr_stats();
    nickel_raw = 1'b1;
    steps(4);
    lock = 1'b1;
    steps(4);
    lock = 1'b0;
    steps(12);
    nickel_raw = 1'b0;
    steps(20);
    chk("lock_nb_cnt", nb_cnt, 0);
    chk("lock_rej_cnt", rej_cnt, 1);
    chk("lock_rej_edge", rej_edge, 7);
    clr_stats();
    nickel_raw = 1'b1;
    steps(10);
    nickel_raw = 1'b0;
    steps(15);
    chk("unlock_nb_cnt", nb_cnt, 1);
    chk("unlock_nb_edge", nb_edge, 7);
    chk("unlock_rej_cnt", rej_cnt, 0);

    // lock discards the pending nickel after a simultaneous press
    clr_stats();
    nickel_raw = 1'b1; dime_raw = 1'b1;
    steps(7);
    lock = 1'b1;
    steps(1);
    lock = 1'b0;
    steps(7);
    nickel_raw = 1'b0; dime_raw = 1'b0;
    steps(15);
    chk("pend_db_cnt", db_cnt, 1);
    chk("pend_nb_cnt", nb_cnt, 0);
    chk("pend_rej_cnt", rej_cnt, 1);
    chk("pend_rej_edge", rej_edge, 8);

    // reset in the middle of ARM, button still held at release
    clr_stats();
    nickel_raw = 1'b1;
    steps(4);
    rst_n = 1'b0;
    steps(3);
    chk("midrst_nb", int'(nb), 0);
    chk("midrst_db", int'(db), 0);
    chk("midrst_rej", int'(coin_reject), 0);
    chk("midrst_nb_cnt", nb_cnt, 0);
    rst_n = 1'b1;
    clr_stats();
    steps(10);
    nickel_raw = 1'b0;
    steps(15);
    chk("midrst_after_cnt", nb_cnt, 1);
    chk("midrst_after_edge", nb_edge, 7);

`ifdef COIN_TALLY_EN
    chk("tally_n_after_rst", int'(nickel_tally), 1);
    chk("tally_d_after_rst", int'(dime_tally), 0);
    tally_clr = 1'b1; steps(1); tally_clr = 1'b0;
    chk("tally_clr0", int'(nickel_tally), 0);
    for (int p = 0; p < 300; p++) press_nickel();
    chk("tally_sat", int'(nickel_tally), 255);
    tally_clr = 1'b1; steps(1); tally_clr = 1'b0;
    chk("tally_clr1", int'(nickel_tally), 0);
    press_nickel();
    chk("tally_one", int'(nickel_tally), 1);
    chk("tally_dime", int'(dime_tally), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
